// File: rtl/mult_bus_master_if.sv
// Bundle of the command, response and slave-bus signals of the multiply bus master.
// The master modport is the initiator's view; the slave modport mirrors it.
interface mult_bus_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_error;

    logic              valid;
    logic              start;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] register_data;
    logic              exec;
    logic              write;
    logic              ready;
    logic [DATA_W-1:0] result_data;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, rsp_ready,
        input  exec, write, ready, result_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_error,
        output valid, start, address, register_data
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, rsp_ready,
        output exec, write, ready, result_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error,
        input  valid, start, address, register_data
    );
endinterface

// File: rtl/mult_bus_master.sv
// Bus initiator: writes two operands to a multiplier slave, requests the product,
// and returns it (or an error on missing acknowledge / timeout) on a response port.
module mult_bus_master #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    mult_bus_master_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_A  = 3'd1,
        S_WR_B  = 3'd2,
        S_ACK_B = 3'd3,
        S_WAIT  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_error_q, rsp_error_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    a_d     = bus.cmd_a;
                    b_d     = bus.cmd_b;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: state_d = S_WR_B;
            S_WR_B: begin
                // exec here acknowledges the operand-A beat of the previous cycle
                if (bus.exec) begin
                    state_d = S_ACK_B;
                end else begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_ACK_B: begin
                if (bus.exec) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_WAIT: begin
                if (bus.ready && bus.write) begin
                    rsp_data_d  = bus.result_data;
                    rsp_error_d = 1'b0;
                    state_d     = S_RESP;
                end else if (cnt_q == LAST_CNT) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from state and latched registers only, so reset releases the bus at once.
    always_comb begin
        bus.cmd_ready     = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.valid         = 1'b0;
        bus.start         = 1'b0;
        bus.address       = '0;
        bus.register_data = '0;
        case (state_q)
            S_IDLE: bus.cmd_ready = 1'b1;
            S_WR_A: begin
                bus.valid         = 1'b1;
                bus.address       = ADDR_W'(1);
                bus.register_data = a_q;
            end
            S_WR_B: begin
                bus.valid         = 1'b1;
                bus.address       = ADDR_W'(2);
                bus.register_data = b_q;
            end
            S_WAIT: bus.start     = 1'b1;
            S_RESP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_mult_bus_master.sv
// Directed bench for mult_bus_master with a small behavioural multiplier slave.
module tb_mult_bus_master;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_bus_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

    mult_bus_master #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave behaviour knobs, written only by the stimulus block.
    logic exec_en;
    logic stall;
    logic stale_en;
    int   mult_delay;

    logic          prev_valid = 1'b0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    int            scnt = 0;
    int            resp_cnt = 0;
    int            addr2_cnt = 0;
    int            start_cnt = 0;

    always @(negedge clk) begin
        prev_valid     <= bus_if.valid;
        bus_if.exec    <= exec_en && prev_valid;
        if (bus_if.valid && bus_if.address == 32'd1) op_a <= bus_if.register_data;
        if (bus_if.valid && bus_if.address == 32'd2) op_b <= bus_if.register_data;
        if (bus_if.start) scnt <= scnt + 1;
        else              scnt <= 0;
        bus_if.ready       <= bus_if.start && !stall && (scnt + 1 == mult_delay);
        bus_if.write       <= bus_if.start && !stall && (scnt + 1 == mult_delay);
        bus_if.result_data <= op_a * op_b;
        // Spurious strobe while the master is between the B beat and WAIT
        if (stale_en && !bus_if.valid && !bus_if.start && !bus_if.cmd_ready && !bus_if.rsp_valid) begin
            bus_if.ready       <= 1'b1;
            bus_if.write       <= 1'b1;
            bus_if.result_data <= 32'hDEAD_BEEF;
        end
        if (bus_if.rsp_valid && bus_if.rsp_ready) resp_cnt <= resp_cnt + 1;
        if (bus_if.valid && bus_if.address == 32'd2) addr2_cnt <= addr2_cnt + 1;
        if (bus_if.start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge of the WR_A cycle.
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, output int acc);
        acc = -1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_a     = a;
        bus_if.cmd_b     = b;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.cmd_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        check("cmd_accepted", 64'(acc >= 0), 64'd1);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_a     = 32'hBAD0_0000;
        bus_if.cmd_b     = 32'h0BAD_0000;
    endtask

    task automatic wait_rsp(output int r);
        r = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus_if.rsp_valid) begin
                r = cyc;
                break;
            end
            @(negedge clk);
        end
        check("rsp_seen", 64'(r >= 0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, r, r2, base_resp, base_a2, base_st;
        reset = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_a     = '0;
        bus_if.cmd_b     = '0;
        bus_if.rsp_ready = 1'b0;
        exec_en    = 1'b1;
        stall      = 1'b0;
        stale_en   = 1'b0;
        mult_delay = 3;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus_if.rsp_data), 64'd0);
        check("rst_rsp_error", 64'(bus_if.rsp_error), 64'd0);
        check("rst_valid", 64'(bus_if.valid), 64'd0);
        check("rst_start", 64'(bus_if.start), 64'd0);
        check("rst_address", 64'(bus_if.address), 64'd0);
        check("rst_wdata", 64'(bus_if.register_data), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal 6*7
        bus_if.rsp_ready = 1'b1;
        base_resp = resp_cnt;
        send_cmd(32'd6, 32'd7, acc);
        check("nom_wra_valid", 64'(bus_if.valid), 64'd1);
        check("nom_wra_addr", 64'(bus_if.address), 64'd1);
        check("nom_wra_data", 64'(bus_if.register_data), 64'd6);
        check("nom_wra_start", 64'(bus_if.start), 64'd0);
        @(negedge clk);
        check("nom_wrb_valid", 64'(bus_if.valid), 64'd1);
        check("nom_wrb_addr", 64'(bus_if.address), 64'd2);
        check("nom_wrb_data", 64'(bus_if.register_data), 64'd7);
        @(negedge clk);
        check("nom_ackb_valid", 64'(bus_if.valid), 64'd0);
        check("nom_ackb_addr", 64'(bus_if.address), 64'd0);
        check("nom_ackb_start", 64'(bus_if.start), 64'd0);
        @(negedge clk);
        check("nom_wait_start", 64'(bus_if.start), 64'd1);
        check("nom_wait_addr", 64'(bus_if.address), 64'd0);
        wait_rsp(r);
        $display("nominal: 6*7 -> data=%0d err=%0d lat=%0d", bus_if.rsp_data, bus_if.rsp_error, r - acc);
        check("nom_data", 64'(bus_if.rsp_data), 64'd42);
        check("nom_err", 64'(bus_if.rsp_error), 64'd0);
        check("nom_latency", 64'(r - acc), 64'd6);
        repeat (2) @(negedge clk);
        check("nom_resp_count", 64'(resp_cnt - base_resp), 64'd1);

        // Back-to-back
        send_cmd(32'd3, 32'd5, acc);
        wait_rsp(r);
        $display("b2b #1: 3*5 -> data=%0h err=%0d", bus_if.rsp_data, bus_if.rsp_error);
        check("b2b1_data", 64'(bus_if.rsp_data), 64'd15);
        check("b2b1_err", 64'(bus_if.rsp_error), 64'd0);
        send_cmd(32'h0000_FFFF, 32'h0001_0001, acc2);
        check("b2b_accept_gap", 64'(acc2 - (r + 1)), 64'd1);
        wait_rsp(r2);
        $display("b2b #2: ffff*10001 -> data=%0h err=%0d", bus_if.rsp_data, bus_if.rsp_error);
        check("b2b2_data", 64'(bus_if.rsp_data), 64'hFFFF_FFFF);
        check("b2b2_err", 64'(bus_if.rsp_error), 64'd0);
        @(negedge clk);

        // Stale strobe during ACK_B must not complete the transaction
        stale_en = 1'b1;
        send_cmd(32'd100, 32'd3, acc);
        wait_rsp(r);
        $display("stale: 100*3 -> data=%0h err=%0d lat=%0d", bus_if.rsp_data, bus_if.rsp_error, r - acc);
        check("stale_data", 64'(bus_if.rsp_data), 64'd300);
        check("stale_latency", 64'(r - acc), 64'd6);
        stale_en = 1'b0;
        @(negedge clk);

        // Backpressure
        bus_if.rsp_ready = 1'b0;
        send_cmd(32'd9, 32'd9, acc);
        wait_rsp(r);
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
            check("bp_rsp_data", 64'(bus_if.rsp_data), 64'd81);
            check("bp_rsp_err", 64'(bus_if.rsp_error), 64'd0);
            check("bp_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
            @(negedge clk);
        end
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        $display("backpressure: 9*9 held 10 cycles, consumed, rsp_valid=%0d", bus_if.rsp_valid);
        check("bp_consumed", 64'(bus_if.rsp_valid), 64'd0);
        check("bp_idle", 64'(bus_if.cmd_ready), 64'd1);

        // Timeout
        stall = 1'b1;
        send_cmd(32'd2, 32'd3, acc);
        wait_rsp(r);
        $display("timeout: data=%0h err=%0d lat=%0d", bus_if.rsp_data, bus_if.rsp_error, r - acc);
        check("to_err", 64'(bus_if.rsp_error), 64'd1);
        check("to_data", 64'(bus_if.rsp_data), 64'd0);
        check("to_latency", 64'(r - acc), 64'd11);
        check("to_start_low", 64'(bus_if.start), 64'd0);
        @(negedge clk);
        stall = 1'b0;

        // Missing acknowledge
        exec_en = 1'b0;
        base_a2 = addr2_cnt;
        base_st = start_cnt;
        send_cmd(32'd4, 32'd5, acc);
        @(negedge clk);
        check("na_wrb_addr", 64'(bus_if.address), 64'd2);
        wait_rsp(r);
        $display("no-ack: data=%0h err=%0d lat=%0d", bus_if.rsp_data, bus_if.rsp_error, r - acc);
        check("na_err", 64'(bus_if.rsp_error), 64'd1);
        check("na_latency", 64'(r - acc), 64'd2);
        repeat (2) @(negedge clk);
        check("na_addr2_beats", 64'(addr2_cnt - base_a2), 64'd1);
        check("na_start_seen", 64'(start_cnt - base_st), 64'd0);
        exec_en = 1'b1;

        // Reset during WAIT cycle 2
        stall = 1'b1;
        base_resp = resp_cnt;
        send_cmd(32'd8, 32'd8, acc);
        repeat (4) @(negedge clk);
        check("rw_in_wait", 64'(bus_if.start), 64'd1);
        #2 reset = 1'b1;
        #1;
        $display("reset in WAIT: start=%0d cmd_ready=%0d valid=%0d", bus_if.start, bus_if.cmd_ready, bus_if.valid);
        check("rw_start", 64'(bus_if.start), 64'd0);
        check("rw_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
        check("rw_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        check("rw_valid", 64'(bus_if.valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rw_no_stale_rsp", 64'(bus_if.rsp_valid), 64'd0);
        end
        send_cmd(32'd11, 32'd13, acc);
        wait_rsp(r);
        $display("after reset: 11*13 -> data=%0d err=%0d lat=%0d", bus_if.rsp_data, bus_if.rsp_error, r - acc);
        check("rw_data", 64'(bus_if.rsp_data), 64'd143);
        check("rw_err", 64'(bus_if.rsp_error), 64'd0);
        check("rw_latency", 64'(r - acc), 64'd6);
        repeat (2) @(negedge clk);
        check("rw_resp_count", 64'(resp_cnt - base_resp), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
